// File: rtl/id_ex.sv
// ID/EX pipeline register: holds decode-stage control, operands and register
// specifiers for one cycle and presents them to the EX stage.
// Every output comes straight from a flop; there is no input-to-output path.
module id_ex #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              RegDst_in,
  input  logic [1:0]        ALU_Op_in,
  input  logic              ALU_Src_in,
  input  logic [DATA_W-1:0] Read_Data_1_in,
  input  logic [DATA_W-1:0] Read_Data_2_in,
  input  logic [DATA_W-1:0] sign_extend_in,
  input  logic [REG_W-1:0]  IF_ID_Rs_in,
  input  logic [REG_W-1:0]  IF_ID_Rt_in,
  input  logic [REG_W-1:0]  ID_Rd_in,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              RegDst_out,
  output logic [1:0]        ALU_Op_out,
  output logic              ALU_Src_out,
  output logic [DATA_W-1:0] Read_Data_1_out,
  output logic [DATA_W-1:0] Read_Data_2_out,
  output logic [DATA_W-1:0] sign_extend_out,
  output logic [REG_W-1:0]  ID_EX_Rs_Forward_out,
  output logic [REG_W-1:0]  ID_EX_Rt_Forward_out,
  output logic [REG_W-1:0]  ID_EX_Rs_MUX_out,
  output logic [REG_W-1:0]  ID_EX_Rt_MUX_out
);

  // Capture every field each edge; reset wins and zeroes the stage into a bubble.
  // Rt is stored twice on purpose: once for forwarding, once as RegDst mux input 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite_out         <= 1'b0;
      MemtoReg_out         <= 1'b0;
      MemRead_out          <= 1'b0;
      MemWrite_out         <= 1'b0;
      RegDst_out           <= 1'b0;
      ALU_Op_out           <= 2'b00;
      ALU_Src_out          <= 1'b0;
      Read_Data_1_out      <= '0;
      Read_Data_2_out      <= '0;
      sign_extend_out      <= '0;
      ID_EX_Rs_Forward_out <= '0;
      ID_EX_Rt_Forward_out <= '0;
      ID_EX_Rs_MUX_out     <= '0;
      ID_EX_Rt_MUX_out     <= '0;
    end else begin
      RegWrite_out         <= RegWrite_in;
      MemtoReg_out         <= MemtoReg_in;
      MemRead_out          <= MemRead_in;
      MemWrite_out         <= MemWrite_in;
      RegDst_out           <= RegDst_in;
      ALU_Op_out           <= ALU_Op_in;
      ALU_Src_out          <= ALU_Src_in;
      Read_Data_1_out      <= Read_Data_1_in;
      Read_Data_2_out      <= Read_Data_2_in;
      sign_extend_out      <= sign_extend_in;
      ID_EX_Rs_Forward_out <= IF_ID_Rs_in;
      ID_EX_Rt_Forward_out <= IF_ID_Rt_in;
      ID_EX_Rs_MUX_out     <= IF_ID_Rt_in;
      ID_EX_Rt_MUX_out     <= ID_Rd_in;
    end
  end

endmodule

// File: tb/tb_id_ex.sv
// Bench for id_ex: a one-edge-delay model checked every cycle, plus directed
// vectors with literal expectations.
module tb_id_ex;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALU_Src_in;
  logic [1:0]  ALU_Op_in;
  logic [31:0] Read_Data_1_in, Read_Data_2_in, sign_extend_in;
  logic [4:0]  IF_ID_Rs_in, IF_ID_Rt_in, ID_Rd_in;
  logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, RegDst_out, ALU_Src_out;
  logic [1:0]  ALU_Op_out;
  logic [31:0] Read_Data_1_out, Read_Data_2_out, sign_extend_out;
  logic [4:0]  ID_EX_Rs_Forward_out, ID_EX_Rt_Forward_out, ID_EX_Rs_MUX_out, ID_EX_Rt_MUX_out;

  int checks = 0;
  int errors = 0;

  id_ex #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .RegDst_in(RegDst_in), .ALU_Op_in(ALU_Op_in),
    .ALU_Src_in(ALU_Src_in), .Read_Data_1_in(Read_Data_1_in), .Read_Data_2_in(Read_Data_2_in),
    .sign_extend_in(sign_extend_in), .IF_ID_Rs_in(IF_ID_Rs_in), .IF_ID_Rt_in(IF_ID_Rt_in),
    .ID_Rd_in(ID_Rd_in),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .RegDst_out(RegDst_out), .ALU_Op_out(ALU_Op_out),
    .ALU_Src_out(ALU_Src_out), .Read_Data_1_out(Read_Data_1_out),
    .Read_Data_2_out(Read_Data_2_out), .sign_extend_out(sign_extend_out),
    .ID_EX_Rs_Forward_out(ID_EX_Rs_Forward_out), .ID_EX_Rt_Forward_out(ID_EX_Rt_Forward_out),
    .ID_EX_Rs_MUX_out(ID_EX_Rs_MUX_out), .ID_EX_Rt_MUX_out(ID_EX_Rt_MUX_out)
  );

  always #5 clk = ~clk;

  // What the EX stage should see: each output field and the input it copies.
  function automatic logic [123:0] in_vec();
    return {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALU_Op_in,
            ALU_Src_in, Read_Data_1_in, Read_Data_2_in, sign_extend_in,
            IF_ID_Rs_in, IF_ID_Rt_in, IF_ID_Rt_in, ID_Rd_in};
  endfunction

  function automatic logic [123:0] out_vec();
    return {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, RegDst_out, ALU_Op_out,
            ALU_Src_out, Read_Data_1_out, Read_Data_2_out, sign_extend_out,
            ID_EX_Rs_Forward_out, ID_EX_Rt_Forward_out, ID_EX_Rs_MUX_out, ID_EX_Rt_MUX_out};
  endfunction

  // Model: outputs are the inputs seen at the previous edge, or zero after a reset edge.
  logic [123:0] exp_q;
  bit           model_valid = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      exp_q       <= '0;
      model_valid <= 1'b1;
    end else begin
      exp_q <= in_vec();
    end
  end

  // Compare the whole stage against the model mid-cycle, once the model is defined.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (out_vec() !== exp_q) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, out_vec(), exp_q);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with every input nonzero.
    reset = 1'b1;
    {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALU_Src_in} = 6'b111111;
    ALU_Op_in = 2'b11;
    Read_Data_1_in = 32'hFFFFFFFF; Read_Data_2_in = 32'hFFFFFFFF; sign_extend_in = 32'hFFFFFFFF;
    IF_ID_Rs_in = 5'd31; IF_ID_Rt_in = 5'd31; ID_Rd_in = 5'd31;
    step();
    check("rst_rd1", Read_Data_1_out, 32'h0);
    check("rst_aluop", {30'b0, ALU_Op_out}, 32'h0);
    check("rst_ctrl", {26'b0, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
                       RegDst_out, ALU_Src_out}, 32'h0);
    check("rst_spec", {12'b0, ID_EX_Rs_Forward_out, ID_EX_Rt_Forward_out,
                       ID_EX_Rs_MUX_out, ID_EX_Rt_MUX_out}, 32'h0);
    check("rst_imm", sign_extend_out, 32'h0);

    // Basic capture; nothing moves before the edge.
    reset = 1'b0;
    Read_Data_1_in = 32'b1010; ALU_Op_in = 2'b10;
    #1;
    check("pre_edge_rd1", Read_Data_1_out, 32'h0);
    step();
    check("cap_rd1", Read_Data_1_out, 32'hA);
    check("cap_aluop", {30'b0, ALU_Op_out}, 32'h2);

    // Specifier routing.
    IF_ID_Rs_in = 5'd3; IF_ID_Rt_in = 5'd7; ID_Rd_in = 5'd12;
    step();
    check("rs_fwd", {27'b0, ID_EX_Rs_Forward_out}, 32'd3);
    check("rt_fwd", {27'b0, ID_EX_Rt_Forward_out}, 32'd7);
    check("rs_mux", {27'b0, ID_EX_Rs_MUX_out}, 32'd7);
    check("rt_mux", {27'b0, ID_EX_Rt_MUX_out}, 32'd12);

    // Load-word control pattern, then R-type.
    RegWrite_in = 1; MemtoReg_in = 1; MemRead_in = 1; ALU_Src_in = 1;
    MemWrite_in = 0; RegDst_in = 0; ALU_Op_in = 2'b00;
    step();
    check("lw_ctrl", {25'b0, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
                      RegDst_out, ALU_Op_out}, 32'b1110000);
    check("lw_alusrc", {31'b0, ALU_Src_out}, 32'd1);
    MemtoReg_in = 0; MemRead_in = 0; ALU_Src_in = 0; RegDst_in = 1; ALU_Op_in = 2'b10;
    step();
    check("r_ctrl", {24'b0, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
                     RegDst_out, ALU_Op_out, ALU_Src_out}, 32'b10001100);

    // Back-to-back data.
    Read_Data_2_in = 32'hA5A5A5A5; sign_extend_in = 32'hFFFF8000;
    step();
    check("b2b_0", Read_Data_2_out, 32'hA5A5A5A5);
    check("imm_neg", sign_extend_out, 32'hFFFF8000);
    Read_Data_2_in = 32'h5A5A5A5A;
    step();
    check("b2b_1", Read_Data_2_out, 32'h5A5A5A5A);
    Read_Data_2_in = 32'h12345678;
    step();
    check("b2b_2", Read_Data_2_out, 32'h12345678);

    // Mid-stream reset with nonzero inputs held, then resume.
    reset = 1'b1;
    step();
    check("mid_rst_rd2", Read_Data_2_out, 32'h0);
    check("mid_rst_ctrl", {29'b0, RegWrite_out, RegDst_out, ALU_Op_out[1]}, 32'h0);
    reset = 1'b0;
    #1;
    check("mid_rst_hold", Read_Data_2_out, 32'h0);
    step();
    check("resume_rd2", Read_Data_2_out, 32'h12345678);
    check("resume_imm", sign_extend_out, 32'hFFFF8000);
    check("resume_rtmux", {27'b0, ID_EX_Rt_MUX_out}, 32'd12);

    // Random traffic, with occasional resets, checked by the model only.
    for (int i = 0; i < 40; i++) begin
      reset = ($urandom_range(0, 9) == 0);
      {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALU_Src_in} = 6'($urandom);
      ALU_Op_in = 2'($urandom);
      Read_Data_1_in = $urandom; Read_Data_2_in = $urandom; sign_extend_in = $urandom;
      IF_ID_Rs_in = 5'($urandom); IF_ID_Rt_in = 5'($urandom); ID_Rd_in = 5'($urandom);
      step();
    end
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
